spare_obs_reader: RTL and testbench
===================================

Name: spare_obs_reader

Overview:
- Read-side companion to the ECO spare-cell cluster.
- On request, snapshots the Q/QB outputs of the spare flops and checks them against the tie-off pattern they must hold.
- Streams a framed serial record out to the test/debug collector over a per-bit valid/ready handshake.
- Sits beside the spare cells in the same clk/resetn domain.

Parameters:
- N_SPARE, 4, number of spare flops observed (≥1).
- EXP_Q, {N_SPARE{1'b0}}, expected Q value of every spare flop. Tie-low mux select makes D=0, so Q=0.
- HDR, 4'hA, frame header, sent MSB first.

Ports:
- clk  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- cap_req  input  1  capture request. Level-sampled; one frame per accepted request.
- spare_q  input  N_SPARE  Q outputs of the spare flops, synchronous to clk.
- spare_qb  input  N_SPARE  QB outputs of the spare flops.
- ser_ready  input  1  collector accepts the current bit.
- ser_valid  output  1  ser_data holds a valid bit.
- ser_data  output  1  serial frame bit.
- ser_last  output  1  current bit is the final (parity) bit.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse after the last bit is accepted.
- mismatch  output  1  sticky: a captured snapshot differed from EXP_Q, or Q != ~QB.
- overrun  output  1  sticky: cap_req seen while busy.
- clr_sticky  input  1  clears mismatch and overrun.

Behaviour:
- Reset (asynchronous, resetn low): state IDLE; all outputs 0; capture register 0; bit counter 0. A reset mid-frame aborts the frame with no done pulse.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: cap_req=1 at an edge does three things:
  - loads snap<=spare_q;
  - computes par<=^spare_q (even parity over data only);
  - goes to SHIFT with cnt=0.
- First valid bit: ser_valid=1 in the cycle after cap_req is sampled (1-cycle latency).
- Frame: F_LEN = 4+N_SPARE+1 bits.
  - HDR[3:0], MSB first;
  - then snap[N_SPARE-1] down to snap[0];
  - then par.
- SHIFT: ser_valid=1 and ser_data=frame[cnt].
  - Transfer occurs on an edge with ser_valid && ser_ready; cnt increments.
  - ser_data and ser_last must stay stable while ready is low. There is no timeout.
  - ser_last=1 exactly when cnt==F_LEN-1.
  - Transfer of the last bit moves to DONE.
- DONE: one cycle, done=1, ser_valid=0, then IDLE.
  - A cap_req sampled in DONE is ignored and sets overrun.
  - A new frame starts from IDLE only, so the minimum gap between frames is 1 idle cycle.
- busy=1 in SHIFT and DONE.
- mismatch set at the capture edge when (spare_q != EXP_Q) or (spare_q != ~spare_qb).
- overrun set on any edge where cap_req=1 and state != IDLE.
- clr_sticky: clears both sticky flags. If set and clear coincide on the same edge, set wins.
- cnt width: $clog2(F_LEN). No wrap: cnt never exceeds F_LEN-1.
- No combinational path from ser_ready to ser_valid/ser_data; all outputs are registered except ser_last, which is decoded from registered cnt.

Decomposition:
- Shared package spare_obs_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - HDR default;
  - frame-length function F_LEN(N).
- One natural sub-module: spare_obs_shreg, the loadable parallel-in/serial-out frame register with hold-on-not-ready. The FSM and sticky flags stay in the top level.

Test Plan (N_SPARE=4, defaults):
- Reset then cap_req pulse, spare_q=0000, spare_qb=1111, ser_ready=1:
  - bits 1,0,1,0,0,0,0,0,0 over 9 consecutive cycles starting 1 cycle after the request;
  - ser_last on the 9th bit; done 1 cycle later;
  - mismatch=0.
- spare_q=0001, spare_qb=1110, ready=1:
  - data bits 0,0,0,1, parity 1;
  - mismatch=1 (≠EXP_Q);
  - clr_sticky pulse -> mismatch=0.
- Backpressure: ser_ready toggles 1,0,0,1,... -> each bit is held stable while ready=0; frame content is unchanged; total cycles = 9 + number of ready-low cycles.
- spare_q=0101, spare_qb=0101 (Q==QB fault) -> parity 0; mismatch=1.
- cap_req held high throughout a frame -> exactly one frame; overrun=1 after it. A second frame starts only after done plus 1 IDLE cycle.
- resetn asserted at bit 5 with ser_ready=1 -> outputs 0 immediately; no done pulse. After release, a new cap_req yields a complete correct frame.

Source files
------------

// File: rtl/spare_obs_pkg.sv
// Shared types and helpers for the spare-cell observation reader.
// Holds the FSM state type, default frame header and frame-length helper.
package spare_obs_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_t;

    localparam int unsigned HDR_W       = 4;
    localparam logic [3:0]  HDR_DEFAULT = 4'hA;

    // Header + one bit per spare flop + parity bit.
    function automatic int unsigned f_len(input int unsigned n);
        return HDR_W + n + 1;
    endfunction

endpackage

// File: rtl/spare_obs_reader_if.sv
// Per-bit valid/ready serial link from the reader to the test/debug collector.
// The reader is the master; the collector drives ser_ready.
interface spare_obs_reader_if;
    logic ser_valid;
    logic ser_data;
    logic ser_last;
    logic ser_ready;

    modport master (
        output ser_valid,
        output ser_data,
        output ser_last,
        input  ser_ready
    );

    modport slave (
        input  ser_valid,
        input  ser_data,
        input  ser_last,
        output ser_ready
    );
endinterface

// File: rtl/spare_obs_shreg.sv
// Loadable parallel-in/serial-out frame register, MSB first.
// Holds its contents unless a shift is requested, so data stays stable under backpressure.
module spare_obs_shreg #(
    parameter int unsigned Width = 9
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_load,
    input  logic [Width-1:0] i_data,
    input  logic             i_shift,
    output logic             o_bit
);

    logic [Width-1:0] r_sr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_data;
        end else if (i_shift) begin
            r_sr <= {r_sr[Width-2:0], 1'b0};
        end
    end

    assign o_bit = r_sr[Width-1];

endmodule

// File: rtl/spare_obs_reader.sv
// Snapshots the spare flops on request, checks them against their tie-off value and
// streams a framed record {HDR, snapshot, parity} out over a per-bit valid/ready link.
module spare_obs_reader
    import spare_obs_pkg::*;
#(
    parameter int unsigned        N_SPARE = 4,
    parameter logic [N_SPARE-1:0] EXP_Q   = '0,
    parameter logic [3:0]         HDR     = HDR_DEFAULT
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               cap_req,
    input  logic [N_SPARE-1:0] spare_q,
    input  logic [N_SPARE-1:0] spare_qb,
    input  logic               clr_sticky,
    spare_obs_reader_if.master ser,
    output logic               busy,
    output logic               done,
    output logic               mismatch,
    output logic               overrun
);

    localparam int unsigned     FLen    = f_len(N_SPARE);
    localparam int unsigned     CntW    = $clog2(FLen);
    localparam logic [CntW-1:0] CntLast = CntW'(FLen - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CntW-1:0]   r_cnt;
    logic [CntW-1:0]   w_cnt_nxt;
    logic              r_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_mismatch;
    logic              r_overrun;
    logic              w_capture;
    logic              w_xfer;
    logic              w_mis_set;
    logic              w_ovr_set;
    logic [FLen-1:0]   w_frame;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_xfer      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (cap_req) begin
                    w_capture   = 1'b1;
                    w_state_nxt = StShift;
                    w_cnt_nxt   = '0;
                end
            end
            StShift: begin
                if (r_valid && ser.ser_ready) begin
                    w_xfer = 1'b1;
                    if (r_cnt == CntLast) begin
                        w_state_nxt = StDone;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            StDone: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    assign w_frame   = {HDR, spare_q, ^spare_q};
    // Both checks are taken only at the capture edge, on the live inputs.
    assign w_mis_set = w_capture && ((spare_q != EXP_Q) || (spare_q != ~spare_qb));
    assign w_ovr_set = cap_req && (r_state != StIdle);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mismatch <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_valid    <= (w_state_nxt == StShift);
            r_busy     <= (w_state_nxt != StIdle);
            r_done     <= (w_state_nxt == StDone);
            r_mismatch <= w_mis_set | (r_mismatch & ~clr_sticky);
            r_overrun  <= w_ovr_set | (r_overrun & ~clr_sticky);
        end
    end

    spare_obs_shreg #(
        .Width (FLen)
    ) u_shreg (
        .clk     (clk),
        .resetn  (resetn),
        .i_load  (w_capture),
        .i_data  (w_frame),
        .i_shift (w_xfer),
        .o_bit   (ser.ser_data)
    );

    assign ser.ser_valid = r_valid;
    assign ser.ser_last  = (r_cnt == CntLast);
    assign busy          = r_busy;
    assign done          = r_done;
    assign mismatch      = r_mismatch;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_spare_obs_reader.sv
// Directed bench for spare_obs_reader with N_SPARE=4 and default parameters.
module tb_spare_obs_reader;

    logic       clk;
    logic       resetn;
    logic       cap_req;
    logic [3:0] spare_q;
    logic [3:0] spare_qb;
    logic       clr_sticky;
    logic       busy;
    logic       done;
    logic       mismatch;
    logic       overrun;
    int         total;
    int         bad;
    int         cyc;

    spare_obs_reader_if sif ();

    spare_obs_reader #(
        .N_SPARE (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cap_req    (cap_req),
        .spare_q    (spare_q),
        .spare_qb   (spare_qb),
        .clr_sticky (clr_sticky),
        .ser        (sif),
        .busy       (busy),
        .done       (done),
        .mismatch   (mismatch),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a request; the caller is at posedge+1. Afterwards the first bit should be showing.
    task automatic start(input logic [3:0] q, input logic [3:0] qb, input bit clr, input bit hold);
        spare_q    = q;
        spare_qb   = qb;
        cap_req    = 1'b1;
        clr_sticky = clr;
        chk("pre_req_valid", sif.ser_valid, 0);
        tick();
        clr_sticky = 1'b0;
        if (!hold) begin
            cap_req = 1'b0;
            spare_q = ~q;
        end
    endtask

    // Accept nbits bits; with bp set, ready is high one cycle in three.
    task automatic recv(input string tag, input logic [8:0] exp, input bit bp, input int nbits,
                        output int ncyc);
        int i;
        int k;
        i    = 0;
        k    = 0;
        ncyc = 0;
        while (i < nbits && ncyc < 200) begin
            sif.ser_ready = bp ? (k % 3 == 0) : 1'b1;
            chk({tag, "_valid"}, sif.ser_valid, 1);
            chk({tag, "_data"}, sif.ser_data, exp[8-i]);
            chk({tag, "_last"}, sif.ser_last, (i == 8));
            chk({tag, "_busy"}, busy, 1);
            tick();
            ncyc++;
            k++;
            if (sif.ser_ready) i++;
        end
        chk({tag, "_bits_accepted"}, i, nbits);
        sif.ser_ready = 1'b1;
    endtask

    task automatic finish_frame(input string tag);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_done_valid"}, sif.ser_valid, 0);
        chk({tag, "_done_busy"}, busy, 1);
        chk({tag, "_done_last"}, sif.ser_last, 0);
        tick();
        chk({tag, "_idle_done"}, done, 0);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        resetn        = 1'b0;
        cap_req       = 1'b0;
        spare_q       = 4'h0;
        spare_qb      = 4'hF;
        clr_sticky    = 1'b0;
        sif.ser_ready = 1'b1;

        tick();
        chk("rst_valid", sif.ser_valid, 0);
        chk("rst_data", sif.ser_data, 0);
        chk("rst_last", sif.ser_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_overrun", overrun, 0);
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Clean snapshot: header A, data 0000, parity 0.
        start(4'h0, 4'hF, 1'b0, 1'b0);
        recv("f1", 9'b1010_0000_0, 1'b0, 9, cyc);
        chk("f1_cycles", cyc, 9);
        finish_frame("f1");
        chk("f1_mismatch", mismatch, 0);
        chk("f1_overrun", overrun, 0);

        // Single flop set: data 0001, parity 1, mismatch against EXP_Q.
        start(4'h1, 4'hE, 1'b0, 1'b0);
        recv("f2", 9'b1010_0001_1, 1'b0, 9, cyc);
        finish_frame("f2");
        chk("f2_mismatch", mismatch, 1);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("f2_cleared", mismatch, 0);

        // Backpressure: 9 transfers at ready pattern 1,0,0 -> 25 cycles.
        start(4'h0, 4'hF, 1'b0, 1'b0);
        recv("bp", 9'b1010_0000_0, 1'b1, 9, cyc);
        chk("bp_cycles", cyc, 25);
        finish_frame("bp");
        chk("bp_mismatch", mismatch, 0);

        // Q==QB fault with a coincident clear: set must win.
        start(4'h5, 4'h5, 1'b1, 1'b0);
        recv("qqb", 9'b1010_0101_0, 1'b0, 9, cyc);
        finish_frame("qqb");
        chk("qqb_mismatch", mismatch, 1);
        clr_sticky = 1'b1;
        tick();
        clr_sticky = 1'b0;
        chk("pre_hold_mismatch", mismatch, 0);
        chk("pre_hold_overrun", overrun, 0);

        // cap_req held: one frame, overrun set, next frame only after done + idle cycle.
        start(4'h0, 4'hF, 1'b0, 1'b1);
        recv("hold1", 9'b1010_0000_0, 1'b0, 9, cyc);
        chk("hold1_overrun", overrun, 1);
        finish_frame("hold1");
        chk("hold_idle_valid", sif.ser_valid, 0);
        tick();
        cap_req = 1'b0;
        recv("hold2", 9'b1010_0000_0, 1'b0, 9, cyc);
        finish_frame("hold2");
        chk("hold2_overrun", overrun, 1);
        chk("hold2_mismatch", mismatch, 0);

        // Reset while the fifth bit is showing aborts the frame.
        start(4'h0, 4'hF, 1'b0, 1'b0);
        recv("abort", 9'b1010_0000_0, 1'b0, 4, cyc);
        #2;
        resetn = 1'b0;
        #1;
        chk("abort_valid", sif.ser_valid, 0);
        chk("abort_data", sif.ser_data, 0);
        chk("abort_last", sif.ser_last, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_overrun", overrun, 0);
        tick();
        @(negedge clk);
        resetn = 1'b1;
        tick();
        chk("post_rst_done", done, 0);
        chk("post_rst_busy", busy, 0);
        start(4'h1, 4'hE, 1'b0, 1'b0);
        recv("post_rst", 9'b1010_0001_1, 1'b0, 9, cyc);
        finish_frame("post_rst");
        chk("post_rst_mismatch", mismatch, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
